// File: rtl/axis_route_stage.sv
// Ingress stage between a vFPGA user-logic stream and the inter-region AXI4-Stream switch.
// Latches the route once per packet, drops packets to disabled/invalid destinations, and skid-buffers the stream.
module axis_route_stage #(
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned PID_BITS  = 6,
  parameter int unsigned DEST_BITS = 2,
  parameter int unsigned N_DEST    = 2,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [7:0]             io_ctrl,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [PID_BITS-1:0]    s_axis_tid,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [PID_BITS-1:0]    m_axis_tid,
  output logic [DEST_BITS-1:0]   m_axis_tdest,
  output logic [CNT_BITS-1:0]    pkt_cnt,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);

  typedef struct packed {
    logic [DATA_BITS-1:0]   data;
    logic [DATA_BITS/8-1:0] keep;
    logic                   last;
    logic [PID_BITS-1:0]    id;
    logic [DEST_BITS-1:0]   dest;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DEST_BITS-1:0] route_q;
  logic [DEST_BITS-1:0] io_dest;
  logic [DEST_BITS-1:0] beat_dest;
  logic                 route_ok;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 drop_done;

  beat_t                in_beat;
  beat_t                main_q;
  beat_t                ovf_q;
  logic                 main_valid_q;
  logic                 ovf_valid_q;
  logic                 ovf_valid_d;
  logic                 rdy_q;

  logic [CNT_BITS-1:0]  pkt_cnt_q;
  logic [15:0]          drop_cnt_q;

  // io_ctrl bits between the dest field and the enable bit carry no meaning here
  logic                 ctrl_unused;
  assign ctrl_unused = &{1'b0, io_ctrl[6:DEST_BITS]};

  assign io_dest  = io_ctrl[DEST_BITS-1:0];
  assign route_ok = io_ctrl[7] && (32'(io_dest) < N_DEST);

  // Dropping never occupies the skid, so ST_DROP may always absorb beats
  assign s_axis_tready = rdy_q || (state_q == ST_DROP);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign pop           = main_valid_q && m_axis_tready;

  always_comb begin
    in_beat      = '0;
    in_beat.data = s_axis_tdata;
    in_beat.keep = s_axis_tkeep;
    in_beat.last = s_axis_tlast;
    in_beat.id   = s_axis_tid;
    in_beat.dest = beat_dest;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && accept && route_ok) begin
        route_q <= io_dest;
      end
    end
  end

  // The route is sampled only on the first accepted beat of a packet
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    drop_done = 1'b0;
    beat_dest = route_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (route_ok) begin
            push      = 1'b1;
            beat_dest = io_dest;
            if (!s_axis_tlast) begin
              state_d = ST_FWD;
            end
          end else if (s_axis_tlast) begin
            drop_done = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        if (accept) begin
          push = 1'b1;
          if (s_axis_tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          drop_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overflow entry fills only when a beat arrives while main is stalled
  assign ovf_valid_d = ovf_valid_q ? !pop : (push && main_valid_q && !pop);

  always_ff @(posedge aclk) begin
    if (areset) begin
      main_valid_q <= 1'b0;
      ovf_valid_q  <= 1'b0;
      main_q       <= '0;
      ovf_q        <= '0;
      rdy_q        <= 1'b0;
    end else begin
      rdy_q       <= !ovf_valid_d;
      ovf_valid_q <= ovf_valid_d;
      if (ovf_valid_q) begin
        if (pop) begin
          main_q <= ovf_q;
        end
      end else if (!main_valid_q || pop) begin
        main_valid_q <= push;
        if (push) begin
          main_q <= in_beat;
        end
      end else if (push) begin
        ovf_q <= in_beat;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop && main_q.last) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_BITS'(1);
      end
      if (drop_done && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign m_axis_tvalid = main_valid_q;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tkeep  = main_q.keep;
  assign m_axis_tlast  = main_q.last;
  assign m_axis_tid    = main_q.id;
  assign m_axis_tdest  = main_q.dest;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_route_stage.sv
// Scoreboard bench for axis_route_stage: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_axis_route_stage;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int PW = 6;
  localparam int DB = 2;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [PW-1:0] id;
    logic [DB-1:0] dest;
  } beat_t;

  logic          aclk;
  logic          areset;
  logic [7:0]    io_ctrl;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic [PW-1:0] s_axis_tid;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [PW-1:0] m_axis_tid;
  logic [DB-1:0] m_axis_tdest;
  logic [CW-1:0] pkt_cnt;
  logic [15:0]   drop_cnt;
  logic          busy;

  int    check_cnt = 0;
  int    err_cnt   = 0;
  int    fwd_acc   = 0;
  int    out_cnt   = 0;
  bit    chk_en    = 0;
  bit    busy_seen = 0;
  bit    hold_v    = 0;
  bit    stim_done = 0;
  beat_t hold_b;
  beat_t exp_q[$];

  axis_route_stage #(
    .DATA_BITS(DW), .PID_BITS(PW), .DEST_BITS(DB), .N_DEST(2), .CNT_BITS(CW)
  ) dut (
    .aclk(aclk), .areset(areset), .io_ctrl(io_ctrl),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .pkt_cnt(pkt_cnt),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [607:0] act, input logic [607:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int tag, input int i, input int n,
                                    input logic [PW-1:0] tid, input logic [DB-1:0] dest);
    beat_t b;
    b.data = {16{8'(tag), 8'(i), 16'hC35A}};
    b.keep = (i == n - 1) ? 64'h0000_0000_FFFF_FFFF : {KW{1'b1}};
    b.last = (i == n - 1);
    b.id   = tid;
    b.dest = dest;
    return b;
  endfunction

  // Holds one beat on the input until accepted; forwarded beats join the scoreboard
  task automatic send_beat(input beat_t b, input bit fwd, output bit ok);
    int  t   = 0;
    bit  acc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tlast  = b.last;
    s_axis_tid    = b.id;
    while (!acc && t < 200) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      t++;
    end
    ok = acc;
    if (!acc) begin
      check_cnt++;
      err_cnt++;
      $display("[TB] FAIL accept_timeout: got no s_axis_tready expected acceptance");
    end else if (fwd) begin
      exp_q.push_back(b);
      fwd_acc++;
    end
  endtask

  task automatic applyStimulus(input int n, input logic [7:0] ctrl, input logic [7:0] ctrl_after,
                               input logic [PW-1:0] tid, input bit fwd, input logic [DB-1:0] dest,
                               input int tag, input bit lat_chk);
    bit ok;
    io_ctrl = ctrl;
    for (int i = 0; i < n; i++) begin
      send_beat(mk_beat(tag, i, n, tid, dest), fwd, ok);
      if (!ok) break;
      if (i == 0) begin
        io_ctrl = ctrl_after;
        if (lat_chk) begin
          checkOutput("latency_valid", 608'(m_axis_tvalid), 608'(1));
          if (n > 1) checkOutput("busy_in_packet", 608'(busy), 608'(1));
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 200) begin
      check_cnt++;
      err_cnt++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    @(posedge aclk);
    #1;
  endtask

  // Monitor: skid occupancy rule, stall stability, and in-order scoreboard compare
  always @(negedge aclk) begin
    beat_t cur;
    beat_t e;
    if (areset) begin
      hold_v = 0;
    end else begin
      if (busy) busy_seen = 1;
      if (chk_en && !s_axis_tready)
        checkOutput("tready_low_occupancy", 608'(fwd_acc - out_cnt), 608'(2));
      if (hold_v)
        checkOutput("stall_stable", 608'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                          m_axis_tid, m_axis_tdest}), 608'({1'b1, hold_b}));
      cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest};
      hold_v = 0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            check_cnt++;
            err_cnt++;
            $display("[TB] FAIL unexpected_beat: got tid=%0h dest=%0h last=%0b expected no beat",
                     cur.id, cur.dest, cur.last);
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_beat", 608'(cur), 608'(e));
          end
        end else begin
          hold_v = 1;
          hold_b = cur;
        end
      end
    end
  end

  initial begin
    bit ok;
    $display("[TB] start");
    areset        = 1'b1;
    io_ctrl       = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tid    = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_m_tvalid", 608'(m_axis_tvalid), 608'(0));
    checkOutput("rst_s_tready", 608'(s_axis_tready), 608'(0));
    checkOutput("rst_pkt_cnt", 608'(pkt_cnt), 608'(0));
    checkOutput("rst_drop_cnt", 608'(drop_cnt), 608'(0));
    checkOutput("rst_busy", 608'(busy), 608'(0));
    checkOutput("rst_tdest", 608'(m_axis_tdest), 608'(0));
    areset = 1'b0;
    @(posedge aclk);
    #1;
    checkOutput("post_rst_s_tready", 608'(s_axis_tready), 608'(1));
    chk_en = 1;

    $display("[TB] basic forward, route 1");
    applyStimulus(4, 8'h81, 8'h81, 6'd5, 1, 2'd1, 1, 1);
    drain();
    checkOutput("t1_pkt_cnt", 608'(pkt_cnt), 608'(1));

    $display("[TB] route change mid-packet");
    applyStimulus(8, 8'h80, 8'h81, 6'd9, 1, 2'd0, 2, 1);
    applyStimulus(2, 8'h81, 8'h81, 6'd9, 1, 2'd1, 3, 0);
    drain();
    checkOutput("t2_pkt_cnt", 608'(pkt_cnt), 608'(3));

    $display("[TB] disabled route drops");
    applyStimulus(3, 8'h01, 8'h01, 6'd7, 0, 2'd0, 4, 0);
    checkOutput("t3_no_output", 608'(m_axis_tvalid), 608'(0));
    checkOutput("t3_drop_cnt", 608'(drop_cnt), 608'(1));
    applyStimulus(2, 8'h80, 8'h80, 6'd7, 1, 2'd0, 5, 0);
    drain();
    checkOutput("t3_pkt_cnt", 608'(pkt_cnt), 608'(4));

    $display("[TB] invalid dest single beat");
    busy_seen = 0;
    applyStimulus(1, 8'h83, 8'h83, 6'd3, 0, 2'd0, 6, 0);
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("t4_drop_cnt", 608'(drop_cnt), 608'(2));
    checkOutput("t4_busy_never", 608'(busy_seen), 608'(0));
    checkOutput("t4_pkt_cnt", 608'(pkt_cnt), 608'(4));

    $display("[TB] random backpressure");
    stim_done = 0;
    fork
      begin
        applyStimulus(8, 8'h81, 8'h81, 6'd12, 1, 2'd1, 7, 0);
        applyStimulus(8, 8'h81, 8'h80, 6'd13, 1, 2'd1, 8, 0);
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge aclk);
          #1;
          m_axis_tready = ($urandom_range(0, 2) == 0);
        end
      end
    join
    m_axis_tready = 1'b1;
    drain();
    checkOutput("t5_pkt_cnt", 608'(pkt_cnt), 608'(6));
    checkOutput("t5_beat_count", 608'(out_cnt), 608'(fwd_acc));

    $display("[TB] reset mid-packet");
    io_ctrl = 8'h81;
    send_beat(mk_beat(9, 0, 6, 6'd2, 2'd1), 1, ok);
    send_beat(mk_beat(9, 1, 6, 6'd2, 2'd1), 1, ok);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk_beat(9, 2, 6, 6'd2, 2'd1).data;
    areset        = 1'b1;
    chk_en        = 0;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    fwd_acc = 0;
    out_cnt = 0;
    checkOutput("t6_m_tvalid", 608'(m_axis_tvalid), 608'(0));
    checkOutput("t6_pkt_cnt", 608'(pkt_cnt), 608'(0));
    checkOutput("t6_drop_cnt", 608'(drop_cnt), 608'(0));
    checkOutput("t6_busy", 608'(busy), 608'(0));
    checkOutput("t6_s_tready", 608'(s_axis_tready), 608'(0));
    areset = 1'b0;
    @(posedge aclk);
    #1;
    checkOutput("t6_s_tready_after", 608'(s_axis_tready), 608'(1));
    chk_en = 1;
    applyStimulus(3, 8'h80, 8'h80, 6'd4, 1, 2'd0, 10, 1);
    drain();
    checkOutput("t6_fresh_pkt_cnt", 608'(pkt_cnt), 608'(1));
    checkOutput("t6_fresh_drop_cnt", 608'(drop_cnt), 608'(0));

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
